// File: rtl/seg_addsub_flags.sv
// Multi-cycle add/subtract: one SLICE-bit slice per clock with a registered carry; N/SLICE+1 cycles from accept to out_valid.
// Results and flags are held in DONE until out_ready; in_ready is low outside IDLE, so new requests stall upstream.
module seg_addsub_flags #(
    parameter int N     = 32,
    parameter int SLICE = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         negative_flag,
    output logic         zero_flag,
    output logic         overflow_flag
);

    localparam int NSLICE = N / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_acc;
    logic           r_carry;
    logic           r_sub;
    logic           r_mode;

    int             w_base;
    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE:0]   w_sl_sum;
    logic [N-1:0]   w_final;
    logic           w_c_msb_in;
    logic           w_c_out;
    logic           w_last;

    // Operands are stored pre-inverted for subtract, so the slice adder only ever adds.
    assign w_base     = int'(r_cnt) * SLICE;
    assign w_a_sl     = r_a[w_base +: SLICE];
    assign w_b_sl     = r_b[w_base +: SLICE];
    assign w_sl_sum   = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
    assign w_c_out    = w_sl_sum[SLICE];
    assign w_c_msb_in = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_sl_sum[SLICE-1];
    assign w_last     = (r_cnt == LAST);

    // The top slice is still combinational on the final RUN edge; splice it in.
    always_comb begin
        w_final                  = r_acc;
        w_final[N-1 -: SLICE]    = w_sl_sum[SLICE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_acc         <= '0;
            r_carry       <= 1'b0;
            r_sub         <= 1'b0;
            r_mode        <= 1'b0;
            sum           <= '0;
            cout          <= 1'b0;
            negative_flag <= 1'b0;
            zero_flag     <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub ^ cin;
                r_sub   <= sub;
                r_mode  <= mode;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_acc[w_base +: SLICE] <= w_sl_sum[SLICE-1:0];
                r_carry                <= w_c_out;
                if (w_last) begin
                    r_cnt         <= '0;
                    sum           <= w_final;
                    cout          <= w_c_out;
                    negative_flag <= w_final[N-1];
                    zero_flag     <= (w_final == '0);
                    // Unsigned: carry for add, borrow (no carry) for subtract.
                    overflow_flag <= r_mode ? (w_c_msb_in ^ w_c_out) : (w_c_out ^ r_sub);
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule
